// File: rtl/conv_psum_gather_if.sv
// conv_psum_gather_if: word-in / six-operand-out handshake bundle for the psum gatherer
interface conv_psum_gather_if #(parameter int DW = 32);
  logic in_valid, in_ready, in_last;
  logic signed [DW-1:0] in_data;
  logic signed [DW-1:0] out_data0, out_data1, out_data2, out_data3, out_data4, out_data5;
  logic out_valid, out_ready, out_en;
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input in_ready, out_data0, out_data1, out_data2, out_data3, out_data4, out_data5, out_valid, out_en
  );
  modport slave (
    input in_valid, in_data, in_last, out_ready,
    output in_ready, out_data0, out_data1, out_data2, out_data3, out_data4, out_data5, out_valid, out_en
  );
endinterface

// File: rtl/conv_psum_gather.sv
// conv_psum_gather: double-buffered serial-to-parallel gather of six partial sums for the add cell
module conv_psum_gather #(
  parameter int N_CH = 6,
  parameter int DW = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic err,
  conv_psum_gather_if.slave bus
);
  typedef enum logic {FILL, FULL} state_t;
  state_t state, state_nxt;
  logic [2:0] cnt, cnt_nxt;
  logic signed [DW-1:0] gbank [N_CH];
  logic signed [DW-1:0] obank [N_CH];
  logic out_valid, out_free, accept, at_end, load;
  assign bus.in_ready = state == FILL;
  assign bus.out_valid = out_valid;
  assign bus.out_en = out_valid & bus.out_ready;
  assign out_free = !out_valid | bus.out_ready;
  assign accept = bus.in_valid & bus.in_ready & !clr;
  assign at_end = cnt == 3'(N_CH - 1);
  assign load = !clr & out_free & ((state == FULL) | (accept & at_end));
  // next gather state: clr or a completed transfer restarts the group, a stalled last word parks in FULL
  always_comb begin
    state_nxt = state;
    cnt_nxt = cnt;
    if (clr || load) begin
      state_nxt = FILL;
      cnt_nxt = '0;
    end else if (accept) begin
      state_nxt = at_end ? FULL : FILL;
      cnt_nxt = at_end ? cnt : cnt + 3'd1;
    end
  end
  // gather state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FILL;
      cnt <= '0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
    end
  end
  // gather bank has no reset: only slots written since the group start are ever forwarded
  always_ff @(posedge clk) begin
    if (accept) gbank[cnt] <= bus.in_data;
  end
  // output bank: the last word bypasses the gather bank when the group closes straight from FILL
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      for (int i = 0; i < N_CH; i++) obank[i] <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      for (int i = 0; i < N_CH; i++) obank[i] <= (i == N_CH - 1 && state == FILL) ? bus.in_data : gbank[i];
    end else if (bus.out_en) begin
      out_valid <= 1'b0;
    end
  end
  // sticky framing error: in_last must coincide exactly with the final channel
  always_ff @(posedge clk) begin
    if (rst) err <= 1'b0;
    else if (accept && (bus.in_last != at_end)) err <= 1'b1;
  end
  assign bus.out_data0 = obank[0];
  assign bus.out_data1 = obank[1];
  assign bus.out_data2 = obank[2];
  assign bus.out_data3 = obank[3];
  assign bus.out_data4 = obank[4];
  assign bus.out_data5 = obank[5];
endmodule

// File: tb/tb_conv_psum_gather.sv
// tb_conv_psum_gather: queue-model scoreboard plus directed scenarios for the psum gatherer
module tb_conv_psum_gather;
  logic clk = 1'b0, rst = 1'b1, clr = 1'b0, err;
  int total = 0, bad = 0, cyc = 0;
  conv_psum_gather_if #(.DW(32)) bus();
  conv_psum_gather #(.N_CH(6), .DW(32)) dut (.clk(clk), .rst(rst), .clr(clr), .err(err), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // group model: a list of gathered words and a six-word output bank
  logic signed [31:0] mg[$];
  logic signed [31:0] mo[6];
  bit mov = 0, merr = 0, known = 0;
  int en_cyc[$];

  always @(posedge clk) begin
    bit free;
    cyc++;
    if (rst) begin
      mg.delete();
      mov = 0;
      merr = 0;
      foreach (mo[i]) mo[i] = 0;
      known = 1;
    end else if (known) begin
      free = !mov || bus.out_ready;
      if (clr) mg.delete();
      else if (bus.in_valid && mg.size() < 6) begin
        if (bus.in_last != (mg.size() == 5)) merr = 1;
        mg.push_back(bus.in_data);
      end
      if (mg.size() == 6 && free) begin
        foreach (mo[i]) mo[i] = mg[i];
        mov = 1;
        mg.delete();
      end else if (mov && bus.out_ready) mov = 0;
    end
  end

  always @(negedge clk) begin
    if (known) begin
      chk("in_ready", bus.in_ready, mg.size() < 6);
      chk("out_valid", bus.out_valid, mov);
      chk("out_en", bus.out_en, mov && bus.out_ready);
      chk("err", err, merr);
      chk("out_data0", bus.out_data0, mo[0]);
      chk("out_data1", bus.out_data1, mo[1]);
      chk("out_data2", bus.out_data2, mo[2]);
      chk("out_data3", bus.out_data3, mo[3]);
      chk("out_data4", bus.out_data4, mo[4]);
      chk("out_data5", bus.out_data5, mo[5]);
      if (bus.out_en) en_cyc.push_back(cyc);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic signed [31:0] v, input logic l);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data = v;
    bus.in_last = l;
    while (!bus.in_ready && n < 100) begin
      step();
      n++;
    end
    chk("accept_timeout", bus.in_ready, 1);
    step();
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
  endtask

  initial begin
    int base;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_last = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_data0", bus.out_data0, 0);

    bus.out_ready = 1'b1;
    for (int i = 1; i <= 6; i++) send(i, i == 6);
    chk("g1_valid", bus.out_valid, 1);
    chk("g1_en", bus.out_en, 1);
    chk("g1_d0", bus.out_data0, 1);
    chk("g1_d5", bus.out_data5, 6);
    chk("g1_err", err, 0);
    step();
    chk("g1_en_once", bus.out_en, 0);

    bus.out_ready = 1'b0;
    for (int v = 10; v <= 21; v++) send(v, (v - 10) % 6 == 5);
    chk("bp_in_ready_low", bus.in_ready, 0);
    chk("bp_d0", bus.out_data0, 10);
    chk("bp_d5", bus.out_data5, 15);
    bus.in_valid = 1'b1;
    bus.in_data = 22;
    repeat (2) begin
      step();
      chk("bp_stall", bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_en", bus.out_en, 1);
    step();
    chk("bp_d0_next", bus.out_data0, 16);
    chk("bp_d5_next", bus.out_data5, 21);
    chk("bp_in_ready_back", bus.in_ready, 1);
    send(22, 0);
    for (int v = 23; v <= 27; v++) send(v, v == 27);
    repeat (2) step();

    base = en_cyc.size();
    for (int v = 200; v < 224; v++) send(v, (v - 200) % 6 == 5);
    step();
    chk("b2b_pulses", en_cyc.size() - base, 4);
    for (int k = base + 1; k < en_cyc.size(); k++) chk("b2b_spacing", en_cyc[k] - en_cyc[k-1], 6);
    chk("b2b_last_d0", bus.out_data0, 218);
    repeat (2) step();

    bus.out_ready = 1'b0;
    for (int v = 7; v <= 9; v++) send(v, 0);
    clr = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data = 99;
    step();
    clr = 1'b0;
    bus.in_valid = 1'b0;
    for (int v = 100; v <= 105; v++) send(v, v == 105);
    chk("fl_valid", bus.out_valid, 1);
    chk("fl_d0", bus.out_data0, 100);
    chk("fl_d1", bus.out_data1, 101);
    chk("fl_d5", bus.out_data5, 105);

    bus.out_ready = 1'b1;
    for (int v = 50; v <= 53; v++) send(v, v == 53);
    chk("fr_err_set", err, 1);
    send(54, 0);
    send(55, 1);
    chk("fr_d0", bus.out_data0, 50);
    chk("fr_d5", bus.out_data5, 55);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("fr_err_survives_clr", err, 1);
    repeat (2) step();

    bus.out_ready = 1'b0;
    for (int v = 30; v <= 41; v++) send(v, (v - 30) % 6 == 5);
    chk("rm_full", bus.in_ready, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rm_valid", bus.out_valid, 0);
    chk("rm_d0", bus.out_data0, 0);
    chk("rm_d5", bus.out_data5, 0);
    chk("rm_in_ready", bus.in_ready, 1);
    chk("rm_err", err, 0);
    for (int i = 1; i <= 6; i++) send(-i, i == 6);
    chk("neg_valid", bus.out_valid, 1);
    chk("neg_d0", bus.out_data0, 32'hFFFF_FFFF);
    chk("neg_d3", bus.out_data3, 32'hFFFF_FFFC);
    chk("neg_d5", bus.out_data5, 32'hFFFF_FFFA);
    chk("neg_err", err, 0);
    repeat (3) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
